skid_register: RTL and testbench

Two-entry ready/valid register slice with skid storage, a synchronous flush and a saturating stall counter. It breaks the timing path on both data/valid and backpressure (ready) between CNN pipeline stages, such as the PE array and the output writer. It is the flow-controlled counterpart to the plain enabled pipeline register: the producer sees a registered `in_ready`, and no beat is lost when the consumer stalls.

---
 rtl/skid_pkg.sv | 16 +
 rtl/skid_register_sat_counter.sv | 44 ++++
 rtl/skid_register.sv | 119 +++++++++++
 tb/tb_skid_register.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// -----------------------------------------------------------------------------
// skid_pkg
// Shared definitions for the skid_register ready/valid slice.
//   skid_state_t : slice state; the encoding doubles as the occupancy count
//                  (EMPTY=0, BUSY=1, FULL=2). Encoding 2'd3 is illegal and
//                  recovers to EMPTY.
// -----------------------------------------------------------------------------
package skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage : skid_pkg

// File: rtl/skid_register_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: counts cycles with inc=1, sticks at all-ones and
// never wraps. Clear has priority over increment.
// Ports:
//   clk     in   clock, rising edge
//   reset_n in   asynchronous active-low reset (count -> 0)
//   clear   in   synchronous clear (count -> 0)
//   inc     in   increment request
//   count   out  CNT_WIDTH current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/skid_register.sv
// -----------------------------------------------------------------------------
// skid_register
// Two-entry ready/valid register slice. Both directions are registered:
// out_valid/out_data come straight from state/main register, and in_ready is
// a flop, so no combinational path crosses the slice. A second (skid) entry
// absorbs the beat accepted in the cycle the consumer first stalls.
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   flush       in   synchronous clear of all stored beats and stall counter
//   in_valid    in   producer has a beat
//   in_ready    out  slice can accept (registered)
//   in_data     in   WIDTH producer payload
//   out_valid   out  slice holds a beat
//   out_ready   in   consumer accepts
//   out_data    out  WIDTH head payload
//   occupancy   out  2 stored beats, 0..2
//   stall_count out  CNT_WIDTH saturating count of out_valid && !out_ready
// -----------------------------------------------------------------------------
module skid_register
    import skid_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_count
);

    skid_state_t      state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_acc, out_acc;

    assign in_acc  = in_valid && in_ready_q;
    assign out_acc = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins; an input beat offered this cycle is dropped.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_acc) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_acc && out_acc) begin
                        main_d = in_data;
                    end else if (in_acc) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_acc) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the consumer can move us.
                    if (out_acc) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        // Registered ready looks one state ahead so the producer never sees
        // ready while the slice is full.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .inc     (out_valid && !out_ready),
        .count   (stall_count)
    );

endmodule : skid_register

// File: tb/tb_skid_register.sv
// -----------------------------------------------------------------------------
// tb_skid_register
// Self-checking bench for skid_register (WIDTH=8, CNT_WIDTH=4) against a
// queue-based reference model of the slice contents and stall count.
// -----------------------------------------------------------------------------
module tb_skid_register;

    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] mq[$];
    int           mstall = 0;

    always #5 clk = ~clk;

    skid_register #(
        .WIDTH     (W),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .stall_count (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("stall_count", 32'(stall_count), 32'(mstall));
        chk("inrdy_when_full", 32'(in_ready && (occupancy == 2'd2)), 32'd0);
        if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    endtask

    // Model of one clock edge, from the rules: accept when room, consume when
    // holding something, flush empties everything.
    task automatic model_edge();
        bit ia, oa, stl;
        ia  = in_valid && (mq.size() < 2);
        oa  = (mq.size() > 0) && out_ready;
        stl = (mq.size() > 0) && !out_ready;
        if (flush) begin
            mq.delete();
            mstall = 0;
        end else begin
            if (oa) void'(mq.pop_front());
            if (ia) mq.push_back(in_data);
            if (stl && mstall < MAXC) mstall++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b0;

        // Reset held across an edge with a beat offered.
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        #5;
        reset_n = 1'b1;
        cycle();
        chk("rst_lat_valid", 32'(out_valid), 32'd1);
        chk("rst_lat_data", 32'(out_data), 32'hA5);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();

        // Clean start, then stream 1..16 back-to-back.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            in_data  = W'(k);
            cycle();
            chk("stream_data", 32'(out_data), 32'(k));
        end
        chk("stream_stall", 32'(stall_count), 32'd0);

        // Consumer stalls for 5 cycles while producer keeps offering.
        out_ready = 1'b0;
        for (int k = 17; k < 22; k++) begin
            in_data = W'(k);
            cycle();
        end
        chk("stall5_cnt", 32'(stall_count), 32'd5);
        chk("stall5_occ", 32'(occupancy), 32'd2);
        chk("stall5_rdy", 32'(in_ready), 32'd0);

        // Drain; order checked by model each cycle.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("drain_head", 32'(out_data), 32'd17);
        repeat (3) cycle();

        // Saturation: hold the consumer off for 20 cycles.
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        out_ready = 1'b0;
        repeat (21) cycle();
        chk("sat_cnt", 32'(stall_count), 32'(MAXC));

        // Flush while FULL with a beat offered in the same cycle.
        chk("pre_flush_occ", 32'(occupancy), 32'd2);
        flush   = 1'b1;
        in_data = 8'hEE;
        cycle();
        flush = 1'b0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_rdy", 32'(in_ready), 32'd1);
        chk("flush_stall", 32'(stall_count), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        // Random traffic, with rare flushes and one mid-run reset.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_data   = W'($urandom);
            if (i == 5000) begin
                reset_n = 1'b0;
                #1;
                chk("midrst_valid", 32'(out_valid), 32'd0);
                chk("midrst_data", 32'(out_data), 32'd0);
                chk("midrst_rdy", 32'(in_ready), 32'd1);
                chk("midrst_stall", 32'(stall_count), 32'd0);
                mq.delete();
                mstall = 0;
                #1;
                reset_n = 1'b1;
            end
            cycle();
        end
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_skid_register
